reg_op_fsm: RTL and testbench

- Parametrised successor to the single-purpose conditional-move FSM.
- Executes one UM register-register instruction per start pulse: conditional move (0), add (3), multiply (4), divide (5) and nand (6).
- Operands are fetched from reg_bank over the shared sel/s/data bus, the result is computed, and it is written back to register A.
- Sits beside the instruction decoder. Its bus outputs feed tribuf_n/tribuf_32 drivers gated by bus_en.

---
 rtl/reg_op_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_reg_op_fsm.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_op_fsm.sv
// reg_op_fsm: one UM register-register op (cmov/add/mul/div/nand) per start pulse over reg_bank bus.
// Optional restoring divider for opcode 5 is enabled by defining REG_OP_DIV_EN.
module reg_op_fsm #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [SEL_W-1:0]  regA,
    input  logic [SEL_W-1:0]  regB,
    input  logic [SEL_W-1:0]  regC,
    input  logic [DATA_W-1:0] reg_data_out,
    output logic [DATA_W-1:0] reg_in_bus,
    output logic [SEL_W-1:0]  reg_sel,
    output logic              reg_s,
    output logic              bus_en,
    output logic              busy,
    output logic              finished,
    output logic              err
);

    localparam logic [3:0] OpCmov = 4'd0;
    localparam logic [3:0] OpAdd  = 4'd3;
    localparam logic [3:0] OpMul  = 4'd4;
    localparam logic [3:0] OpNand = 4'd6;
`ifdef REG_OP_DIV_EN
    localparam logic [3:0] OpDiv  = 4'd5;
    localparam int unsigned CntW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StRdB,
        StRdC,
        StExec,
        StWrA,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [SEL_W-1:0]   ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic [DATA_W-1:0]  opb_q, opb_d, opc_q, opc_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic               err_q, err_d;
`ifdef REG_OP_DIV_EN
    logic [DATA_W-1:0]  rem_q, rem_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [DATA_W:0]    rem_sh;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        rc_d       = rc_q;
        opb_d      = opb_q;
        opc_d      = opc_q;
        res_d      = res_q;
        err_d      = err_q;
        reg_in_bus = '0;
        reg_sel    = '0;
        reg_s      = 1'b0;
        bus_en     = 1'b0;
        finished   = 1'b0;
        err        = 1'b0;
        busy       = (state_q != StIdle);
`ifdef REG_OP_DIV_EN
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        // Result register doubles as the dividend/quotient shift register.
        rem_sh     = {rem_q, res_q[DATA_W-1]};
`endif

        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = opcode;
                    ra_d    = regA;
                    rb_d    = regB;
                    rc_d    = regC;
                    err_d   = 1'b0;
                    state_d = StRdB;
                end
            end
            StRdB: begin
                bus_en  = 1'b1;
                reg_sel = rb_q;
                opb_d   = reg_data_out;
                state_d = StRdC;
            end
            StRdC: begin
                bus_en  = 1'b1;
                reg_sel = rc_q;
                opc_d   = reg_data_out;
`ifdef REG_OP_DIV_EN
                res_d   = opb_q;
                rem_d   = '0;
                cnt_d   = '0;
`endif
                state_d = StExec;
            end
            StExec: begin
                case (op_q)
                    OpCmov: begin
                        if (opc_q != '0) begin
                            res_d   = opb_q;
                            state_d = StWrA;
                        end else begin
                            state_d = StDone;
                        end
                    end
                    OpAdd: begin
                        res_d   = opb_q + opc_q;
                        state_d = StWrA;
                    end
                    OpMul: begin
                        res_d   = opb_q * opc_q;
                        state_d = StWrA;
                    end
                    OpNand: begin
                        res_d   = ~(opb_q & opc_q);
                        state_d = StWrA;
                    end
`ifdef REG_OP_DIV_EN
                    OpDiv: begin
                        if (opc_q == '0) begin
                            err_d   = 1'b1;
                            state_d = StDone;
                        end else begin
                            if (rem_sh >= {1'b0, opc_q}) begin
                                rem_d = rem_sh[DATA_W-1:0] - opc_q;
                                res_d = {res_q[DATA_W-2:0], 1'b1};
                            end else begin
                                rem_d = rem_sh[DATA_W-1:0];
                                res_d = {res_q[DATA_W-2:0], 1'b0};
                            end
                            cnt_d = cnt_q + CntW'(1);
                            if (cnt_q == CntW'(DATA_W - 1)) begin
                                state_d = StWrA;
                            end
                        end
                    end
`endif
                    default: begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                endcase
            end
            StWrA: begin
                bus_en     = 1'b1;
                reg_sel    = ra_q;
                reg_in_bus = res_q;
                reg_s      = 1'b1;
                state_d    = StDone;
            end
            StDone: begin
                finished = 1'b1;
                err      = err_q;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            opb_q   <= '0;
            opc_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
`ifdef REG_OP_DIV_EN
            rem_q   <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            opb_q   <= opb_d;
            opc_q   <= opc_d;
            res_q   <= res_d;
            err_q   <= err_d;
`ifdef REG_OP_DIV_EN
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_reg_op_fsm.sv
// Self-checking bench for reg_op_fsm: reg_bank stand-in, directed test-plan cases, abort-in-write
// case and randomized ops against an arithmetic reference model.
module tb_reg_op_fsm;

    localparam int DW = 32;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    opcode = '0;
    logic [SW-1:0] regA = '0, regB = '0, regC = '0;
    logic [DW-1:0] reg_data_out, reg_in_bus;
    logic [SW-1:0] reg_sel;
    logic          reg_s, bus_en, busy, finished, err;

    logic [DW-1:0] regs [8];
    logic          pl_we = 1'b0;
    logic [SW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    int            wr_cnt = 0;
    int            checks = 0;
    int            failures = 0;

    reg_op_fsm #(.DATA_W(DW), .SEL_W(SW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .opcode       (opcode),
        .regA         (regA),
        .regB         (regB),
        .regC         (regC),
        .reg_data_out (reg_data_out),
        .reg_in_bus   (reg_in_bus),
        .reg_sel      (reg_sel),
        .reg_s        (reg_s),
        .bus_en       (bus_en),
        .busy         (busy),
        .finished     (finished),
        .err          (err)
    );

    always #5 clk = ~clk;

    assign reg_data_out = regs[reg_sel];

    // Register bank: bench preload port has priority, otherwise DUT write strobe.
    always @(posedge clk) begin
        if (pl_we) begin
            regs[pl_addr] <= pl_data;
        end else if (reg_s) begin
            regs[reg_sel] <= reg_in_bus;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [SW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_we = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Reference model: outcome of one instruction from the operand values alone.
    task automatic model(input logic [3:0] op, input logic [DW-1:0] b, input logic [DW-1:0] c,
                         output logic [DW-1:0] res, output bit we, output bit e, output int lat);
        res = '0;
        we  = 1'b0;
        e   = 1'b0;
        lat = 4;
        case (op)
            4'd0: if (c != 0) begin res = b; we = 1'b1; lat = 5; end
            4'd3: begin res = b + c; we = 1'b1; lat = 5; end
            4'd4: begin res = b * c; we = 1'b1; lat = 5; end
            4'd6: begin res = ~(b & c); we = 1'b1; lat = 5; end
`ifdef REG_OP_DIV_EN
            4'd5: if (c == 0) e = 1'b1; else begin res = b / c; we = 1'b1; lat = 4 + DW; end
`endif
            default: e = 1'b1;
        endcase
    endtask

    task automatic run_op(input logic [3:0] op, input logic [SW-1:0] a, input logic [SW-1:0] b,
                          input logic [SW-1:0] c, input bit disturb);
        logic [DW-1:0] exp_regs [8];
        logic [DW-1:0] res;
        bit            we, e;
        int            lat_exp, lat, pulse_at, w0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) exp_regs[i] = regs[i];
        model(op, regs[b], regs[c], res, we, e, lat_exp);
        if (we) exp_regs[a] = res;
        w0 = wr_cnt;
        opcode = op;
        regA = a;
        regB = b;
        regC = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            opcode = 4'($urandom);
            regA = 3'($urandom);
            regB = 3'($urandom);
            regC = 3'($urandom);
        end
        pulse_at = disturb ? int'($urandom_range(1, lat_exp - 1)) : 0;
        lat = 1;
        while (finished !== 1'b1 && lat < 100) begin
            start = (lat == pulse_at);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check_val("latency", lat, lat_exp);
        check_val("err", err, e);
        check_val("busy_in_done", busy, 1);
        @(negedge clk);
        check_val("finished_pulse", finished, 0);
        check_val("idle_after", busy, 0);
        for (int i = 0; i < 8; i++) check_val($sformatf("r%0d", i), regs[i], exp_regs[i]);
        check_val("write_count", wr_cnt - w0, we);
    endtask

    initial begin
        int n, fin_cnt, w0;
        logic [DW-1:0] r0_save;
        for (int i = 0; i < 8; i++) preload(3'(i), 32'h0);
        check_val("rst_reg_in_bus", reg_in_bus, 0);
        check_val("rst_reg_sel", reg_sel, 0);
        check_val("rst_reg_s", reg_s, 0);
        check_val("rst_bus_en", bus_en, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_finished", finished, 0);
        check_val("rst_err", err, 0);
        @(negedge clk);
        reset = 1'b1;

        // cmov taken and not taken
        preload(3'd2, 32'd1);
        preload(3'd4, 32'h5555);
        preload(3'd1, 32'hCCCC);
        run_op(4'd0, 3'd1, 3'd4, 3'd2, 1'b0);
        check_val("cmov_r1", regs[1], 32'h5555);
        preload(3'd2, 32'd0);
        preload(3'd1, 32'hCCCC);
        run_op(4'd0, 3'd1, 3'd4, 3'd2, 1'b0);
        check_val("cmov0_r1", regs[1], 32'hCCCC);

        preload(3'd3, 32'hFFFF_FFFF);
        preload(3'd5, 32'h2);
        run_op(4'd3, 3'd0, 3'd3, 3'd5, 1'b0);
        check_val("add_r0", regs[0], 32'h1);
        preload(3'd3, 32'h1_0000);
        run_op(4'd4, 3'd0, 3'd3, 3'd3, 1'b0);
        check_val("mul_r0", regs[0], 32'h0);
        preload(3'd6, 32'hF0F0_F0F0);
        preload(3'd7, 32'hFF00_FF00);
        run_op(4'd6, 3'd0, 3'd6, 3'd7, 1'b0);
        check_val("nand_r0", regs[0], 32'h0FFF_0FFF);

        preload(3'd3, 32'd100);
        preload(3'd5, 32'd7);
        run_op(4'd5, 3'd0, 3'd3, 3'd5, 1'b0);
`ifdef REG_OP_DIV_EN
        check_val("div_r0", regs[0], 32'd14);
`endif
        preload(3'd5, 32'd0);
        run_op(4'd5, 3'd0, 3'd3, 3'd5, 1'b0);
        run_op(4'd9, 3'd0, 3'd3, 3'd5, 1'b0);

        // Abort by reset while the write strobe is up.
        preload(3'd5, 32'd9);
        @(negedge clk);
        r0_save = regs[0];
        w0 = wr_cnt;
        opcode = 4'd3;
        regA = 3'd0;
        regB = 3'd3;
        regC = 3'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (reg_s !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_val("reach_write", reg_s, 1);
        reset = 1'b0;
        #1;
        check_val("abort_reg_s", reg_s, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_bus_en", bus_en, 0);
        @(negedge clk);
        reset = 1'b1;
        fin_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (finished === 1'b1) fin_cnt++;
        end
        check_val("abort_no_finished", fin_cnt, 0);
        check_val("abort_no_write", wr_cnt - w0, 0);
        check_val("abort_r0", regs[0], r0_save);
        run_op(4'd3, 3'd0, 3'd3, 3'd5, 1'b0);

        // Randomized ops, with input disturbance and a stray start during busy.
        for (int it = 0; it < 40; it++) begin
            logic [3:0] op;
            case ($urandom_range(0, 7))
                0: op = 4'd0;
                1: op = 4'd3;
                2: op = 4'd4;
                3: op = 4'd5;
                4: op = 4'd6;
                5: op = 4'd5;
                6: op = 4'd0;
                default: op = 4'($urandom);
            endcase
            for (int r = 0; r < 8; r++) begin
                case ($urandom_range(0, 3))
                    0: preload(3'(r), 32'h0);
                    1: preload(3'(r), 32'($urandom_range(1, 300)));
                    default: preload(3'(r), 32'($urandom));
                endcase
            end
            run_op(op, 3'($urandom), 3'($urandom), 3'($urandom), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
